// File: rtl/fwd_hazard_ctrl.sv
// EX-stage operand forwarding selects plus load-use stall and branch flush control.
// Optional build macro HAZARD_PERF_EN adds saturating stall/flush cycle counters.
module fwd_hazard_ctrl #(
  parameter int REG_AW       = 5,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic              branch_taken,
  output logic              stall_if_id,
  output logic              bubble_id_ex,
  output logic              flush_if_id,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       stall_count,
  output logic [31:0]       flush_count
`endif
);

  localparam logic [1:0] ST_RUN      = 2'b00;
  localparam logic [1:0] ST_LU_STALL = 2'b01;
  localparam logic [1:0] ST_FLUSH    = 2'b10;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  localparam logic [2:0] FLUSH_LOAD  = 3'(FLUSH_CYCLES - 1);
  localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);

  logic [1:0] state_r;
  logic [1:0] state_n_s;
  logic [2:0] flush_cnt_r;
  logic [2:0] flush_cnt_n_s;
  logic       load_use_s;
  logic       in_flush_s;
  logic       flush_s;
  logic       stall_s;
  logic       bubble_s;
  logic [1:0] fwd_a_sel_r;
  logic [1:0] fwd_b_sel_r;
  logic [1:0] fwd_a_n_s;
  logic [1:0] fwd_b_n_s;

  // Newest producer wins; x0 is never treated as a producer.
  function automatic logic [1:0] pick_sel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] e_rd,
    input logic              e_rw,
    input logic [REG_AW-1:0] m_rd,
    input logic              m_rw
  );
    logic [1:0] sel;
    if (e_rw && (e_rd != {REG_AW{1'b0}}) && (e_rd == rs)) begin
      sel = SEL_MEM;
    end else if (m_rw && (m_rd != {REG_AW{1'b0}}) && (m_rd == rs)) begin
      sel = SEL_WB;
    end else begin
      sel = SEL_RF;
    end
    return sel;
  endfunction

  // Hazard detection; a flush overrides the stall so the redirected PC can load.
  always_comb begin
    load_use_s = 1'b0;
    if (id_valid && ex_memread && (ex_rd != {REG_AW{1'b0}}) &&
        ((ex_rd == id_rs1) || (ex_rd == id_rs2))) begin
      load_use_s = 1'b1;
    end else begin
      load_use_s = 1'b0;
    end
    in_flush_s = (state_r == ST_FLUSH);
    flush_s    = branch_taken || in_flush_s;
    stall_s    = load_use_s && !flush_s;
    bubble_s   = branch_taken || load_use_s || in_flush_s;
  end

  assign stall_if_id  = stall_s;
  assign bubble_id_ex = bubble_s;
  assign flush_if_id  = flush_s;

  // Next-state logic: branch_taken from any state (re)loads the flush counter.
  always_comb begin
    state_n_s     = state_r;
    flush_cnt_n_s = flush_cnt_r;
    if (branch_taken) begin
      if (MULTI_FLUSH) begin
        state_n_s     = ST_FLUSH;
        flush_cnt_n_s = FLUSH_LOAD;
      end else begin
        state_n_s     = ST_RUN;
        flush_cnt_n_s = 3'd0;
      end
    end else begin
      case (state_r)
        ST_RUN: begin
          if (load_use_s) begin
            state_n_s = ST_LU_STALL;
          end else begin
            state_n_s = ST_RUN;
          end
        end
        ST_LU_STALL: begin
          state_n_s = ST_RUN;
        end
        ST_FLUSH: begin
          if (flush_cnt_r <= 3'd1) begin
            state_n_s     = ST_RUN;
            flush_cnt_n_s = 3'd0;
          end else begin
            state_n_s     = ST_FLUSH;
            flush_cnt_n_s = flush_cnt_r - 3'd1;
          end
        end
        default: begin
          state_n_s     = ST_RUN;
          flush_cnt_n_s = 3'd0;
        end
      endcase
    end
  end

  // Forwarding selects travel with the instruction into EX; bubbles carry 00.
  always_comb begin
    fwd_a_n_s = SEL_RF;
    fwd_b_n_s = SEL_RF;
    if (bubble_s || !id_valid) begin
      fwd_a_n_s = SEL_RF;
      fwd_b_n_s = SEL_RF;
    end else begin
      fwd_a_n_s = pick_sel(id_rs1, ex_rd, ex_regwrite, mem_rd, mem_regwrite);
      fwd_b_n_s = pick_sel(id_rs2, ex_rd, ex_regwrite, mem_rd, mem_regwrite);
    end
  end

  // State, flush counter and select registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_RUN;
      flush_cnt_r <= 3'd0;
      fwd_a_sel_r <= SEL_RF;
      fwd_b_sel_r <= SEL_RF;
    end else begin
      state_r     <= state_n_s;
      flush_cnt_r <= flush_cnt_n_s;
      fwd_a_sel_r <= fwd_a_n_s;
      fwd_b_sel_r <= fwd_b_n_s;
    end
  end

  assign fwd_a_sel = fwd_a_sel_r;
  assign fwd_b_sel = fwd_b_sel_r;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_count_r;
  logic [31:0] flush_count_r;

  // Saturating cycle counters for stall and flush activity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_r <= 32'd0;
      flush_count_r <= 32'd0;
    end else begin
      if (stall_s && (stall_count_r != 32'hFFFF_FFFF)) begin
        stall_count_r <= stall_count_r + 32'd1;
      end
      if (flush_s && (flush_count_r != 32'hFFFF_FFFF)) begin
        flush_count_r <= flush_count_r + 32'd1;
      end
    end
  end

  assign stall_count = stall_count_r;
  assign flush_count = flush_count_r;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed plus random checks of fwd_hazard_ctrl against a cycle-level reference model.
// Counter checks are compiled in when HAZARD_PERF_EN is defined.
module tb_fwd_hazard_ctrl;
  localparam int FC = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
  logic       ex_regwrite, ex_memread, mem_regwrite, branch_taken;
  logic       stall_if_id, bubble_id_ex, flush_if_id;
  logic [1:0] fwd_a_sel, fwd_b_sel;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_count, flush_count;
`endif

  int total = 0;
  int bad   = 0;
  int flush_left = 0;       // flush cycles still owed after the current one
  logic [1:0] exp_a = 2'b00;
  logic [1:0] exp_b = 2'b00;
  int exp_sc = 0;
  int exp_fc = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_AW(5), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .branch_taken(branch_taken),
    .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex), .flush_if_id(flush_if_id),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
`ifdef HAZARD_PERF_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] rule_sel(input logic [4:0] rs);
    if (ex_regwrite && ex_rd != 5'd0 && ex_rd == rs) return 2'b10;
    if (mem_regwrite && mem_rd != 5'd0 && mem_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic idle();
    id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0; mem_rd = 5'd0;
    ex_regwrite = 1'b0; ex_memread = 1'b0; mem_regwrite = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic model_reset();
    flush_left = 0; exp_a = 2'b00; exp_b = 2'b00; exp_sc = 0; exp_fc = 0;
  endtask

  // Called at posedge+1 with inputs applied; checks combinational outputs, then the edge.
  task automatic cyc();
    logic lu, fl, st, bu;
    logic [1:0] na, nb;
    #3;
    lu = id_valid && ex_memread && ex_rd != 5'd0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
    fl = branch_taken || (flush_left > 0);
    st = lu && !fl;
    bu = branch_taken || lu || (flush_left > 0);
    chk("flush", flush_if_id, fl);
    chk("stall", stall_if_id, st);
    chk("bubble", bubble_id_ex, bu);
    na = (bu || !id_valid) ? 2'b00 : rule_sel(id_rs1);
    nb = (bu || !id_valid) ? 2'b00 : rule_sel(id_rs2);
    if (st) exp_sc++;
    if (fl) exp_fc++;
    @(posedge clk);
    #1;
    if (branch_taken) flush_left = FC - 1;
    else if (flush_left > 0) flush_left--;
    exp_a = na;
    exp_b = nb;
    chk("sel_a", fwd_a_sel, exp_a);
    chk("sel_b", fwd_b_sel, exp_b);
`ifdef HAZARD_PERF_EN
    chk("stall_count", stall_count, exp_sc);
    chk("flush_count", flush_count, exp_fc);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    #2;
    chk("rst_flush", flush_if_id, 1'b0);
    chk("rst_stall", stall_if_id, 1'b0);
    chk("rst_bubble", bubble_id_ex, 1'b0);
    chk("rst_sel_a", fwd_a_sel, 2'b00);
    chk("rst_sel_b", fwd_b_sel, 2'b00);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // forward from EX
    idle(); id_valid = 1'b1; ex_rd = 5'd5; ex_regwrite = 1'b1; id_rs1 = 5'd5; id_rs2 = 5'd6;
    cyc();
    chk("exfwd_a", fwd_a_sel, 2'b10);
    chk("exfwd_b", fwd_b_sel, 2'b00);

    // double match: EX wins
    idle(); id_valid = 1'b1; ex_rd = 5'd7; mem_rd = 5'd7; ex_regwrite = 1'b1;
    mem_regwrite = 1'b1; id_rs2 = 5'd7; id_rs1 = 5'd1;
    cyc();
    chk("dbl_b", fwd_b_sel, 2'b10);
    ex_rd = 5'd0; mem_rd = 5'd0; id_rs2 = 5'd0;
    cyc();
    chk("x0_b", fwd_b_sel, 2'b00);
    chk("x0_a", fwd_a_sel, 2'b00);

    // load-use then MEM forward
    idle(); id_valid = 1'b1; ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3;
    #2;
    chk("lu_stall", stall_if_id, 1'b1);
    chk("lu_bubble", bubble_id_ex, 1'b1);
    #1;
    cyc();
    chk("lu_sel_a", fwd_a_sel, 2'b00);
    ex_memread = 1'b0; ex_regwrite = 1'b0; ex_rd = 5'd0; mem_rd = 5'd3; mem_regwrite = 1'b1;
    #2;
    chk("lu_done", stall_if_id, 1'b0);
    #1;
    cyc();
    chk("memfwd_a", fwd_a_sel, 2'b01);

    // branch flush lasts FC cycles
    idle(); branch_taken = 1'b1;
    cyc();
    branch_taken = 1'b0;
    #2; chk("br_flush_c2", flush_if_id, 1'b1); chk("br_bubble_c2", bubble_id_ex, 1'b1); #1;
    cyc();
    #2; chk("br_flush_end", flush_if_id, 1'b0); #1;
    cyc();

    // branch together with load-use, then retrigger inside FLUSH
    idle(); id_valid = 1'b1; ex_memread = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; branch_taken = 1'b1;
    #2; chk("sim_stall", stall_if_id, 1'b0); chk("sim_flush", flush_if_id, 1'b1); #1;
    cyc();
    idle(); branch_taken = 1'b1;
    cyc();
    branch_taken = 1'b0;
    #2; chk("retrig_flush", flush_if_id, 1'b1); #1;
    cyc();
    #2; chk("retrig_end", flush_if_id, 1'b0); #1;
    cyc();

    // async reset mid-flush and with a live select
    idle(); id_valid = 1'b1; ex_rd = 5'd4; ex_regwrite = 1'b1; id_rs1 = 5'd4;
    cyc();
    chk("pre_rst_a", fwd_a_sel, 2'b10);
    idle(); branch_taken = 1'b1;
    cyc();
    branch_taken = 1'b0;
    #2;
    chk("mid_flush", flush_if_id, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_flush", flush_if_id, 1'b0);
    chk("arst_bubble", bubble_id_ex, 1'b0);
    model_reset();
    #1; rst_n = 1'b1;
    @(posedge clk); #1;
    idle(); id_valid = 1'b1; mem_rd = 5'd8; mem_regwrite = 1'b1; id_rs2 = 5'd8;
    cyc();
    chk("pre_rst_b", fwd_b_sel, 2'b01);
    idle();
    #2; rst_n = 1'b0; #1;
    chk("arst_sel_b", fwd_b_sel, 2'b00);
    model_reset();
    #1; rst_n = 1'b1;
    @(posedge clk); #1;
`ifdef HAZARD_PERF_EN
    chk("perf_rst_s", stall_count, 32'd0);
    chk("perf_rst_f", flush_count, 32'd0);
    idle(); id_valid = 1'b1; ex_memread = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3;
    for (int i = 0; i < 3; i++) cyc();
    chk("perf_three", stall_count, 32'd3);
`endif

    // random traffic on a small register pool to force frequent matches
    for (int n = 0; n < 400; n++) begin
      id_valid     = ($urandom_range(0, 3) != 0);
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      ex_rd        = 5'($urandom_range(0, 3));
      mem_rd       = 5'($urandom_range(0, 3));
      ex_regwrite  = 1'($urandom_range(0, 1));
      ex_memread   = ex_regwrite && ($urandom_range(0, 2) == 0);
      mem_regwrite = 1'($urandom_range(0, 1));
      branch_taken = ($urandom_range(0, 7) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Control-side partner of the 32-bit 2:1 datapath selectors in the pipelined RISC-V core.
- Watches the ID, EX and MEM stages and generates the registered select codes for the EX-stage operand forwarding muxes.
- Drives the load-use stall and branch-flush controls for the IF/ID and ID/EX pipeline registers.
- Sits beside the ID/EX register; its outputs are consumed by the forwarding mux tree and the PC/pipeline-register enables.

Parameters:
- REG_AW, 5, register-address width.
- FLUSH_CYCLES, 2, total cycles flush_if_id stays asserted per taken branch (1..7).

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_rs1  input  REG_AW  ID source register 1.
- id_rs2  input  REG_AW  ID source register 2.
- ex_rd  input  REG_AW  EX destination register.
- ex_regwrite  input  1  EX instruction writes rd.
- ex_memread  input  1  EX instruction is a load.
- mem_rd  input  REG_AW  MEM destination register.
- mem_regwrite  input  1  MEM instruction writes rd.
- branch_taken  input  1  EX resolved a taken branch/jump (1-cycle pulse).
- stall_if_id  output  1  hold PC and IF/ID (combinational).
- bubble_id_ex  output  1  load NOP into ID/EX (combinational).
- flush_if_id  output  1  invalidate IF/ID (combinational + FSM).
- fwd_a_sel  output  2  registered select for operand A, aligned with EX.
- fwd_b_sel  output  2  registered select for operand B, aligned with EX.

Behaviour:
- Interface: single clock clk; reset rst_n is asynchronous, active-low.
- Select encoding: 00 = register-file value, 01 = WB result, 10 = MEM result. Code 11 is never driven.
- Register x0 never matches: any rd == 0 is treated as no producer.
- Next-select rule for rsN, evaluated in the ID stage:
  - ex_regwrite && ex_rd == rsN → 10 (producer will be in MEM when the consumer reaches EX).
  - else mem_regwrite && mem_rd == rsN → 01.
  - else 00.
  - The EX match has priority (newest value wins).
- fwd_*_sel register on every clk edge. The registered value is forced to 00 when bubble_id_ex=1 or id_valid=0. Latency is 1 cycle: sel lands with the instruction entering EX.
- Load-use condition: id_valid && ex_memread && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2).
  - Effect: stall_if_id=1 and bubble_id_ex=1 in the same cycle.
  - Next cycle the load is in MEM; the generic rule then yields 01 for the consumer. No extra state is needed beyond the 1-cycle stall.
- FSM states: RUN, LU_STALL, FLUSH.
  - RUN → LU_STALL on the load-use condition.
  - LU_STALL → RUN unconditionally after 1 cycle. A repeat match is impossible because EX now holds the bubble.
  - Any state → FLUSH on branch_taken, with flush_cnt loaded to FLUSH_CYCLES-1.
  - FLUSH decrements flush_cnt each cycle; → RUN when flush_cnt reaches 0 while asserted.
  - If FLUSH_CYCLES=1, branch_taken asserts flush for that cycle only and the FSM stays in RUN.
- flush_if_id = branch_taken || (state==FLUSH).
- bubble_id_ex = branch_taken || load-use condition || (state==FLUSH).
- Simultaneous events:
  - branch_taken together with load-use: flush wins, stall_if_id=0 (the redirected PC must load).
  - A new branch_taken arriving in FLUSH reloads flush_cnt.
- Reset values: state=RUN, flush_cnt=0, fwd_a_sel=fwd_b_sel=00. Combinational outputs read 0 while inputs are idle.
- Reset asserted mid-stall or mid-flush: all of the above clear immediately, with no clock required.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined:
  - Adds output stall_count[31:0], incremented on every cycle with stall_if_id=1.
  - Adds output flush_count[31:0], incremented on every cycle with flush_if_id=1.
  - Both counters saturate at 32'hFFFFFFFF and are cleared by rst_n.
- Undefined: both ports and both counters are absent. Behaviour is otherwise identical.

Test Plan:
- Forward from EX: ex_rd=5, ex_regwrite=1, id_rs1=5, id_rs2=6 → after 1 clk, fwd_a_sel=10, fwd_b_sel=00; no stall.
- Double match: ex_rd=7 and mem_rd=7, both regwrite, id_rs2=7 → fwd_b_sel=10 (EX priority). With rd=0 on both instead, sels stay 00.
- Load-use: ex_memread=1, ex_rd=3, id_rs1=3 → stall_if_id=1 and bubble_id_ex=1 for exactly 1 cycle, registered sels 00. Next cycle, with mem_rd=3 and mem_regwrite=1 → fwd_a_sel=01 after the clk.
- Branch flush, FLUSH_CYCLES=2: branch_taken pulse → flush_if_id=1 for exactly 2 cycles, bubble_id_ex=1 for both, then RUN.
- Simultaneous branch_taken and load-use → stall_if_id=0, flush_if_id=1. A second branch_taken in FLUSH extends the flush by FLUSH_CYCLES from that cycle.
- Async reset: assert rst_n=0 mid-FLUSH between clock edges → flush_if_id=0 and sels 00 immediately. With HAZARD_PERF_EN, counters read 0, and 3 stall cycles give stall_count=3.
